// File: rtl/uio_arb_pkg.sv
// Shared constants for the UIO bus arbiter: bus width, counter widths and
// the FSM state encoding.
package uio_arb_pkg;

    localparam int BUS_W  = 8;
    localparam int TURN_W = 4;
    localparam int HOLD_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v,
                                                   input logic [HOLD_W-1:0] lim);
        return (v >= lim) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Requester handshake plus pad-side signals of the UIO bus arbiter.
interface uio_bus_arbiter_if;

    logic                            req_a;
    logic                            req_b;
    logic [uio_arb_pkg::BUS_W-1:0]   dout_a;
    logic [uio_arb_pkg::BUS_W-1:0]   dout_b;
    logic [uio_arb_pkg::BUS_W-1:0]   oe_a;
    logic [uio_arb_pkg::BUS_W-1:0]   oe_b;
    logic                            gnt_a;
    logic                            gnt_b;
    logic [uio_arb_pkg::BUS_W-1:0]   uio_in;
    logic [uio_arb_pkg::BUS_W-1:0]   uio_out;
    logic [uio_arb_pkg::BUS_W-1:0]   uio_oe;
    logic [uio_arb_pkg::BUS_W-1:0]   din;
    logic                            busy;

    modport slave (
        input  req_a, req_b, dout_a, dout_b, oe_a, oe_b, uio_in,
        output gnt_a, gnt_b, uio_out, uio_oe, din, busy
    );

    modport master (
        output req_a, req_b, dout_a, dout_b, oe_a, oe_b, uio_in,
        input  gnt_a, gnt_b, uio_out, uio_oe, din, busy
    );

endinterface

// File: rtl/uio_in_sync.sv
// Two-flop synchronizer for the raw pad input bus.
module uio_in_sync
    import uio_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] i_d,
    output logic [BUS_W-1:0] o_q
);

    logic [BUS_W-1:0] r_s1;
    logic [BUS_W-1:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/uio_bus_arbiter.sv
// Two-requester arbiter for a shared bidirectional pad bus, with bounded
// ownership and an undriven turnaround gap between owners.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 16
) (
    input logic              clk,
    input logic              rst_n,
    uio_bus_arbiter_if.slave bus
);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_last_b;
    logic              r_armed;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_inc;
    logic              w_timeout;
    logic [TURN_W-1:0] r_turn;
    logic [BUS_W-1:0]  r_uio_out;
    logic [BUS_W-1:0]  r_uio_oe;
    logic [BUS_W-1:0]  w_din;

    // Timeout fires on the owner's MAX_HOLD-th grant cycle, so exactly
    // MAX_HOLD cycles are granted before a waiting peer takes over.
    assign w_hold_inc = sat_inc(r_hold, HOLD_MAX);
    assign w_timeout  = (w_hold_inc == HOLD_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_armed) begin
                    if (bus.req_a && bus.req_b) w_next = r_last_b ? ST_OWN_A : ST_OWN_B;
                    else if (bus.req_a)         w_next = ST_OWN_A;
                    else if (bus.req_b)         w_next = ST_OWN_B;
                end
            end
            ST_OWN_A: if (!bus.req_a || (w_timeout && bus.req_b)) w_next = ST_TURN;
            ST_OWN_B: if (!bus.req_b || (w_timeout && bus.req_a)) w_next = ST_TURN;
            ST_TURN: begin
                if (r_turn == TURN_LAST) begin
                    if (r_last_b ? bus.req_a : bus.req_b)      w_next = r_last_b ? ST_OWN_A : ST_OWN_B;
                    else if (r_last_b ? bus.req_b : bus.req_a) w_next = r_last_b ? ST_OWN_B : ST_OWN_A;
                    else                                       w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // r_armed holds off any grant until the second edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_last_b  <= 1'b1;
            r_armed   <= 1'b0;
            r_hold    <= '0;
            r_turn    <= '0;
            r_uio_out <= '0;
            r_uio_oe  <= '0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            r_hold  <= ((r_state == ST_OWN_A || r_state == ST_OWN_B) && w_next == r_state)
                       ? w_hold_inc : '0;
            r_turn  <= (r_state == ST_TURN && w_next == ST_TURN) ? r_turn + 1'b1 : '0;
            if (r_state == ST_OWN_A && w_next == ST_TURN) r_last_b <= 1'b0;
            if (r_state == ST_OWN_B && w_next == ST_TURN) r_last_b <= 1'b1;
            case (w_next)
                ST_OWN_A: begin
                    r_uio_out <= bus.dout_a;
                    r_uio_oe  <= bus.oe_a;
                end
                ST_OWN_B: begin
                    r_uio_out <= bus.dout_b;
                    r_uio_oe  <= bus.oe_b;
                end
                default: begin
                    r_uio_out <= '0;
                    r_uio_oe  <= '0;
                end
            endcase
        end
    end

    uio_in_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.uio_in),
        .o_q   (w_din)
    );

    assign bus.gnt_a   = (r_state == ST_OWN_A);
    assign bus.gnt_b   = (r_state == ST_OWN_B);
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.uio_out = r_uio_out;
    assign bus.uio_oe  = r_uio_oe;
    assign bus.din     = w_din;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Three arbiter configurations driven with shared directed and random stimulus,
// checked every cycle against an ownership-level reference model.
module tb_uio_bus_arbiter;

    localparam int N = 3;

    function automatic int tp(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic int hp(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [7:0] dout_a = '0, dout_b = '0, oe_a = '0, oe_b = '0, uio_in = '0;

    logic [N-1:0] gnt_a_o, gnt_b_o, busy_o;
    logic [7:0]   out_o [N];
    logic [7:0]   oe_o  [N];
    logic [7:0]   din_o [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uio_bus_arbiter_if bus ();
        assign bus.req_a  = req_a;
        assign bus.req_b  = req_b;
        assign bus.dout_a = dout_a;
        assign bus.dout_b = dout_b;
        assign bus.oe_a   = oe_a;
        assign bus.oe_b   = oe_b;
        assign bus.uio_in = uio_in;
        uio_bus_arbiter #(.TURN_CYCLES((g == 2) ? 3 : 1), .MAX_HOLD((g == 0) ? 16 : 4)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign gnt_a_o[g] = bus.gnt_a;
        assign gnt_b_o[g] = bus.gnt_b;
        assign busy_o[g]  = bus.busy;
        assign out_o[g]   = bus.uio_out;
        assign oe_o[g]    = bus.uio_oe;
        assign din_o[g]   = bus.din;
    end

    // Reference model: who owns the bus (0 none, 1 A, 2 B), turnaround cycles
    // remaining, last owner, grant cycles used, edges since reset.
    typedef struct packed {
        int         own;
        int         turn;
        int         last;
        int         held;
        int         edges;
        logic [7:0] out;
        logic [7:0] oe;
    } mst_t;

    mst_t       m [N];
    logic [7:0] m_s1, m_s2;

    function automatic mst_t mreset();
        mst_t r;
        r.own = 0; r.turn = 0; r.last = 2; r.held = 0; r.edges = 0;
        r.out = '0; r.oe = '0;
        return r;
    endfunction

    function automatic logic rq(input int who, input logic ra, input logic rb);
        return (who == 1) ? ra : rb;
    endfunction

    function automatic mst_t mstep(input mst_t s, input int tc, input int mh,
                                   input logic ra, input logic rb,
                                   input logic [7:0] da, input logic [7:0] db,
                                   input logic [7:0] oa, input logic [7:0] ob);
        mst_t n;
        int   h;
        n = s;
        if (s.own == 0 && s.turn == 0) begin
            if (s.edges >= 1) begin
                if (ra && rb)  n.own = 3 - s.last;
                else if (ra)   n.own = 1;
                else if (rb)   n.own = 2;
                n.held = 0;
            end
        end else if (s.own != 0) begin
            h = (s.held + 1 > mh) ? mh : s.held + 1;
            if (!rq(s.own, ra, rb) || (h >= mh && rq(3 - s.own, ra, rb))) begin
                n.last = s.own; n.own = 0; n.turn = tc; n.held = 0;
            end else begin
                n.held = h;
            end
        end else begin
            n.turn = s.turn - 1;
            if (n.turn == 0) begin
                if (rq(3 - s.last, ra, rb)) n.own = 3 - s.last;
                else if (rq(s.last, ra, rb)) n.own = s.last;
            end
        end
        n.out = (n.own == 1) ? da : (n.own == 2) ? db : 8'h00;
        n.oe  = (n.own == 1) ? oa : (n.own == 2) ? ob : 8'h00;
        if (s.edges < 1000) n.edges = s.edges + 1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m[i] <= mreset();
            m_s1 <= '0;
            m_s2 <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                m[i] <= mstep(m[i], tp(i), hp(i), req_a, req_b, dout_a, dout_b, oe_a, oe_b);
            m_s1 <= uio_in;
            m_s2 <= m_s1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d gnt_a", i), 32'(gnt_a_o[i]), 32'(m[i].own == 1));
            chk($sformatf("u%0d gnt_b", i), 32'(gnt_b_o[i]), 32'(m[i].own == 2));
            chk($sformatf("u%0d busy", i), 32'(busy_o[i]), 32'(m[i].own != 0 || m[i].turn != 0));
            chk($sformatf("u%0d uio_out", i), 32'(out_o[i]), 32'(m[i].out));
            chk($sformatf("u%0d uio_oe", i), 32'(oe_o[i]), 32'(m[i].oe));
            chk($sformatf("u%0d din", i), 32'(din_o[i]), 32'(m_s2));
            chk($sformatf("u%0d overlap", i), 32'(gnt_a_o[i] & gnt_b_o[i]), 32'd0);
        end
    endtask

    // Advance to the next falling edge and compare every instance there.
    task automatic cyc();
        @(negedge clk);
        compare_all();
    endtask

    // Leaves rst_n low at a falling edge; the caller releases it.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        cyc();
        cyc();
        chk("reset gnt_a", 32'(gnt_a_o[0]), 32'd0);
        chk("reset uio_oe", 32'(oe_o[0]), 32'h00);
        chk("reset busy", 32'(busy_o[0]), 32'd0);

        // Both requesters rise with reset release: A wins, no grant on first edge.
        rst_n = 1'b1; req_a = 1'b1; req_b = 1'b1;
        dout_a = 8'h5A; oe_a = 8'hFF; dout_b = 8'hC3; oe_b = 8'h0F;
        cyc();
        chk("first edge no grant", 32'(gnt_a_o[0] | gnt_b_o[0]), 32'd0);
        cyc();
        chk("tie gnt_a", 32'(gnt_a_o[0]), 32'd1);
        chk("A uio_oe", 32'(oe_o[0]), 32'hFF);
        chk("A uio_out", 32'(out_o[0]), 32'h5A);
        req_a = 1'b0;
        cyc();
        chk("turn uio_oe", 32'(oe_o[0]), 32'h00);
        chk("turn no grant", 32'(gnt_a_o[0] | gnt_b_o[0]), 32'd0);
        cyc();
        chk("handover gnt_b", 32'(gnt_b_o[0]), 32'd1);
        chk("B uio_oe", 32'(oe_o[0]), 32'h0F);

        // Preemption on the MAX_HOLD=4 instance.
        req_b = 1'b0;
        do_reset();
        rst_n = 1'b1; req_a = 1'b1;
        cyc();
        cyc();
        chk("preempt A cyc1", 32'(gnt_a_o[1]), 32'd1);
        req_b = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            cyc();
            chk($sformatf("preempt A cyc%0d", k), 32'(gnt_a_o[1]), 32'd1);
        end
        cyc();
        chk("preempt turn gnt", 32'(gnt_a_o[1] | gnt_b_o[1]), 32'd0);
        chk("preempt turn oe", 32'(oe_o[1]), 32'h00);
        cyc();
        chk("preempt gnt_b", 32'(gnt_b_o[1]), 32'd1);

        // TURN_CYCLES=3 release to idle.
        req_a = 1'b0; req_b = 1'b0;
        do_reset();
        rst_n = 1'b1; req_a = 1'b1;
        cyc();
        cyc();
        chk("t3 gnt_a", 32'(gnt_a_o[2]), 32'd1);
        req_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("t3 turn oe %0d", k), 32'(oe_o[2]), 32'h00);
            chk($sformatf("t3 turn busy %0d", k), 32'(busy_o[2]), 32'd1);
        end
        cyc();
        chk("t3 idle busy", 32'(busy_o[2]), 32'd0);

        // Asynchronous reset in the middle of a B ownership cycle.
        do_reset();
        rst_n = 1'b1; req_b = 1'b1; oe_b = 8'h0F;
        cyc();
        cyc();
        chk("pre-reset oe_b", 32'(oe_o[0]), 32'h0F);
        #2 rst_n = 1'b0;
        #1;
        chk("async uio_oe", 32'(oe_o[0]), 32'h00);
        chk("async uio_out", 32'(out_o[0]), 32'h00);
        chk("async gnt_b", 32'(gnt_b_o[0]), 32'd0);
        chk("async busy", 32'(busy_o[0]), 32'd0);
        cyc();
        rst_n = 1'b1;

        // uio_in step reaches din two edges later while B owns the bus.
        uio_in = 8'h00;
        cyc();
        cyc();
        cyc();
        uio_in = 8'hA5;
        cyc();
        chk("din after 1", 32'(din_o[0]), 32'h00);
        cyc();
        chk("din after 2", 32'(din_o[0]), 32'hA5);

        // Random traffic with occasional mid-cycle resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) req_a = ~req_a;
            if ($urandom_range(0, 7) == 0) req_b = ~req_b;
            dout_a = 8'($urandom); dout_b = 8'($urandom);
            oe_a   = 8'($urandom); oe_b   = 8'($urandom);
            uio_in = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uio_bus_arbiter.md
UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 Parameter TURN_CYCLES, default 1: bus-idle cycles (uio_oe = 0) between owners; legal range 1..15.
REQ-002 Parameter MAX_HOLD, default 16: owner grant cycles before it is preempted by a waiting peer; legal range 1..255.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_a, req_b  in  1 each  requester A/B wants the bidirectional bus; held high for the whole use.
REQ-006 dout_a, dout_b  in  8 each  requester data to drive.
REQ-007 oe_a, oe_b  in  8 each  requester per-bit output enables.
REQ-008 gnt_a, gnt_b  out  1 each  requester owns bus; registered, never both high.
REQ-009 uio_in  in  8  raw pad input.
REQ-010 uio_out  out  8  pad output data, registered.
REQ-011 uio_oe  out  8  pad output enables, registered, 1 = drive.
REQ-012 din  out  8  uio_in after 2-flop synchronizer.
REQ-013 busy  out  1  high whenever state != IDLE.

Function
REQ-014 FSM states IDLE, OWN_A, OWN_B, TURN; gnt_x = (state == OWN_x).
REQ-015 IDLE: req_a only -> OWN_A; req_b only -> OWN_B; both -> owner opposite last_owner; none -> stay.
REQ-016 IDLE -> OWN_x takes no turnaround (bus already undriven); gnt_x rises one cycle after req_x is sampled high.
REQ-017 OWN_x: hold_cnt clears on entry, increments each cycle, saturates at MAX_HOLD.
REQ-018 OWN_x -> TURN when req_x low, or when hold_cnt == MAX_HOLD and peer req high; otherwise stay; last_owner <= x on exit.
REQ-019 Peer request never preempts before MAX_HOLD grant cycles; with no peer request, owner holds indefinitely.
REQ-020 TURN lasts exactly TURN_CYCLES cycles; exit to OWN_peer if peer req high on last cycle, else OWN_x if req_x high, else IDLE.
REQ-021 uio_out/uio_oe load dout_x/oe_x at every edge where next state is OWN_x; at every other edge load 8'h00/8'h00.
REQ-022 Consequence: uio_oe is 0 for all TURN cycles and in IDLE; data latency dout_x -> uio_out is 1 cycle.
REQ-023 Simultaneous owner release and timeout: single transition to TURN, no double counting.
REQ-024 Requester dropping req during TURN: FSM exits to IDLE (or the other requester) with no grant pulse.
REQ-025 din is uio_in delayed by exactly 2 cycles, independent of FSM state.

Reset
REQ-026 rst_n low: state IDLE, last_owner = B (A wins first tie), hold_cnt 0, turn_cnt 0, gnt_a/gnt_b 0, uio_out 0, uio_oe 0, din 0, busy 0.
REQ-027 Reset asserted mid-ownership forces uio_oe to 0 immediately (asynchronously), without waiting for clk.
REQ-028 First grant after reset release occurs no earlier than the second rising edge after rst_n rises.

Structure
REQ-029 Shared package uio_arb_pkg holds the state encoding, the BUS_W = 8 constant, and the counter widths (4-bit turn, 8-bit hold).
REQ-030 One sub-module, uio_in_sync (2-flop, 8-bit, async reset to 0), produces din; everything else is flat in uio_bus_arbiter.

Verification
REQ-031 req_a = 1 from IDLE, oe_a = 8'hFF, dout_a = 8'h5A -> gnt_a high at next edge, uio_oe = FF and uio_out = 5A in the same cycle.
REQ-032 req_a and req_b both rise in the same cycle from reset -> A granted; A releases -> exactly 1 cycle with uio_oe = 00, then gnt_b.
REQ-033 MAX_HOLD = 4, A holds, B requests at A's cycle 1 -> A preempted after 4 grant cycles, TURN 1 cycle, gnt_b; gnt_a/gnt_b never overlap.
REQ-034 TURN_CYCLES = 3, A releases while B is idle -> uio_oe = 00 for 3 cycles, then IDLE, busy low.
REQ-035 rst_n pulled low mid-cycle during OWN_B with oe_b = 8'h0F -> uio_oe = 00 before the next clk edge, all outputs at reset values.
REQ-036 uio_in steps 00 -> A5 -> din = A5 exactly 2 cycles later, in any FSM state.
